// File: rtl/cook_ctrl.sv
// Microwave cooking controller: keypad time entry, BCD MM:SS countdown,
// pause on door/stop, and a timed done alarm.
module cook_ctrl #(
    parameter int unsigned BEEP_SECS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state,
    output logic       beep
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_COOK  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int CW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_SECS - 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    mt_q, mt_d;
    logic [3:0]    mo_q, mo_d;
    logic [3:0]    st_q, st_d;
    logic [3:0]    so_q, so_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic start_prev_q;
    logic stop_prev_q;
    logic clear_prev_q;

    logic start_p;
    logic stop_p;
    logic clear_p;
    logic any_p;

    logic key_ok;
    logic shift_nz;

    logic [3:0] dec_mt;
    logic [3:0] dec_mo;
    logic [3:0] dec_st;
    logic [3:0] dec_so;
    logic       dec_zero;

    // A press is a falling edge; holding the button low yields one press.
    assign start_p = ~startn & start_prev_q;
    assign stop_p  = ~stopn  & stop_prev_q;
    assign clear_p = ~clearn & clear_prev_q;
    assign any_p   = start_p | stop_p | clear_p;

    // Digits above 9 are not BCD and are dropped.
    assign key_ok   = key_valid && (key_digit <= 4'd9);
    assign shift_nz = (mo_q != 4'd0) || (st_q != 4'd0) ||
                      (so_q != 4'd0) || (key_digit != 4'd0);

    // One-second BCD borrow chain; sec_tens may hold 6-9 from the keypad.
    always_comb begin
        dec_mt = mt_q;
        dec_mo = mo_q;
        dec_st = st_q;
        dec_so = so_q;
        if (so_q != 4'd0) begin
            dec_so = so_q - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (st_q != 4'd0) begin
                dec_st = st_q - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (mo_q != 4'd0) begin
                    dec_mo = mo_q - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = mt_q - 4'd1;
                end
            end
        end
    end

    assign dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                      (dec_st == 4'd0) && (dec_so == 4'd0);

    // Next state and time: clear > stop > door > countdown > start > key.
    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (key_ok) begin
                    mt_d = mo_q;
                    mo_d = st_q;
                    st_d = so_q;
                    so_d = key_digit;
                    if (shift_nz) begin
                        state_d = S_SET;
                    end
                end
            end
            S_SET: begin
                if (clear_p || stop_p) begin
                    state_d = S_IDLE;
                    mt_d    = 4'd0;
                    mo_d    = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                end else if (start_p && door_closed) begin
                    state_d = S_COOK;
                end else if (key_ok) begin
                    mt_d = mo_q;
                    mo_d = st_q;
                    st_d = so_q;
                    so_d = key_digit;
                    if (!shift_nz) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_COOK: begin
                if (clear_p) begin
                    state_d = S_IDLE;
                    mt_d    = 4'd0;
                    mo_d    = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                end else if (stop_p || !door_closed) begin
                    state_d = S_PAUSE;
                end else if (tick_1hz) begin
                    mt_d = dec_mt;
                    mo_d = dec_mo;
                    st_d = dec_st;
                    so_d = dec_so;
                    if (dec_zero) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (clear_p || stop_p) begin
                    state_d = S_IDLE;
                    mt_d    = 4'd0;
                    mo_d    = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                end else if (start_p && door_closed) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (any_p || !door_closed) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (tick_1hz) begin
                    if (cnt_q == BEEP_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                mt_d    = 4'd0;
                mo_d    = 4'd0;
                st_d    = 4'd0;
                so_d    = 4'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Button history for edge detection; released state after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            clear_prev_q <= 1'b1;
        end else begin
            start_prev_q <= startn;
            stop_prev_q  <= stopn;
            clear_prev_q <= clearn;
        end
    end

    // Controller state, time digits and alarm counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mag_on   = (state_q == S_COOK) && door_closed;
    assign beep     = (state_q == S_DONE);
    assign state    = state_q;
    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;

endmodule

// File: tb/tb_cook_ctrl.sv
// Directed self-checking bench for cook_ctrl.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_cook_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       mag_on;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] state;
    logic       beep;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SET   = 3'd1;
    localparam logic [2:0] COOK  = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    cook_ctrl #(.BEEP_SECS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .mag_on      (mag_on),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .state       (state),
        .beep        (beep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] tm();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic press_start();
        startn = 1'b0;
        step();
        startn = 1'b1;
        step();
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        step();
        stopn = 1'b1;
        step();
    endtask

    task automatic press_clear();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        step();
    endtask

    initial begin
        rst         = 1'b1;
        tick_1hz    = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        step();
        step();
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_time", 32'(tm()), 32'h0000);
        check("rst_beep", 32'(beep), 32'd0);
        check("rst_mag", 32'(mag_on), 32'd0);
        rst = 1'b0;
        step();

        // Keys 1,3,0 then start
        key(4'd1);
        check("key1_state", 32'(state), 32'(SET));
        key(4'd3);
        key(4'd0);
        check("k130_time", 32'(tm()), 32'h0130);
        check("k130_state", 32'(state), 32'(SET));
        startn = 1'b0;
        step();
        check("start_state", 32'(state), 32'(COOK));
        check("start_mag", 32'(mag_on), 32'd1);
        startn = 1'b1;
        step();

        // 01:00 -> 00:59
        press_clear();
        check("clr_state", 32'(state), 32'(IDLE));
        check("clr_time", 32'(tm()), 32'h0000);
        key(4'd1);
        key(4'd0);
        key(4'd0);
        press_start();
        tick();
        check("dec_0100", 32'(tm()), 32'h0059);

        // 00:02 -> DONE, then beep for 3 ticks
        press_clear();
        key(4'd2);
        press_start();
        tick();
        check("dec_0002", 32'(tm()), 32'h0001);
        check("dec_0002_st", 32'(state), 32'(COOK));
        tick();
        check("done_state", 32'(state), 32'(DONE));
        check("done_mag", 32'(mag_on), 32'd0);
        check("done_beep", 32'(beep), 32'd1);
        check("done_time", 32'(tm()), 32'h0000);
        tick();
        tick();
        check("beep2_state", 32'(state), 32'(DONE));
        tick();
        check("beep3_state", 32'(state), 32'(IDLE));
        check("beep3_beep", 32'(beep), 32'd0);

        // Door open at 00:40
        key(4'd4);
        key(4'd0);
        press_start();
        check("k40_time", 32'(tm()), 32'h0040);
        door_closed = 1'b0;
        #1;
        check("door_mag_comb", 32'(mag_on), 32'd0);
        check("door_state_comb", 32'(state), 32'(COOK));
        step();
        check("door_pause", 32'(state), 32'(PAUSE));
        tick();
        tick();
        check("pause_frozen", 32'(tm()), 32'h0040);
        door_closed = 1'b1;
        step();
        step();
        check("close_stays", 32'(state), 32'(PAUSE));
        press_start();
        check("resume_state", 32'(state), 32'(COOK));
        check("resume_mag", 32'(mag_on), 32'd1);

        // Clear + start + tick in one cycle
        clearn   = 1'b0;
        startn   = 1'b0;
        tick_1hz = 1'b1;
        step();
        check("combo_state", 32'(state), 32'(IDLE));
        check("combo_time", 32'(tm()), 32'h0000);
        check("combo_mag", 32'(mag_on), 32'd0);
        clearn   = 1'b1;
        startn   = 1'b1;
        tick_1hz = 1'b0;
        step();

        // 23:45 and invalid key
        for (int i = 1; i <= 5; i++) key(4'(i));
        check("k12345", 32'(tm()), 32'h2345);
        key(4'd12);
        check("key12_ign", 32'(tm()), 32'h2345);
        press_stop();
        check("set_stop_st", 32'(state), 32'(IDLE));
        check("set_stop_tm", 32'(tm()), 32'h0000);

        // 00:90 counts 90 ticks
        key(4'd9);
        key(4'd0);
        check("k90", 32'(tm()), 32'h0090);
        press_start();
        tick();
        check("k90_t1", 32'(tm()), 32'h0089);
        for (int i = 0; i < 88; i++) tick();
        check("k90_t89_st", 32'(state), 32'(COOK));
        check("k90_t89_tm", 32'(tm()), 32'h0001);
        tick();
        check("k90_t90", 32'(state), 32'(DONE));
        press_clear();
        check("done_btn", 32'(state), 32'(IDLE));

        // Held start gives one press
        key(4'd5);
        startn = 1'b0;
        for (int i = 0; i < 50; i++) step();
        check("hold_state", 32'(state), 32'(COOK));
        stopn = 1'b0;
        step();
        stopn = 1'b1;
        step();
        step();
        check("hold_pause", 32'(state), 32'(PAUSE));
        startn = 1'b1;
        step();
        press_start();
        check("hold_recook", 32'(state), 32'(COOK));

        // Reset mid-cook
        rst = 1'b1;
        step();
        check("rst_cook_st", 32'(state), 32'(IDLE));
        check("rst_cook_mag", 32'(mag_on), 32'd0);
        check("rst_cook_tm", 32'(tm()), 32'h0000);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cook_ctrl.md
COOK_CTRL -- requirements
Module: cook_ctrl

Interface
REQ-001 The block SHALL have one parameter: BEEP_SECS, 3, number of tick_1hz pulses the done alarm stays active.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 tick_1hz  input  1  one-cycle pulse per second from the external prescaler.
REQ-006 startn  input  1  start button, active-low.
REQ-007 stopn  input  1  stop/pause button, active-low.
REQ-008 clearn  input  1  clear button, active-low.
REQ-009 door_closed  input  1  1 = door closed.
REQ-010 key_valid  input  1  one-cycle strobe qualifying key_digit.
REQ-011 key_digit  input  4  keypad digit, BCD.
REQ-012 mag_on  output  1  magnetron enable.
REQ-013 min_tens, min_ones, sec_tens, sec_ones  output  4 each  remaining time, BCD, MM:SS.
REQ-014 state  output  3  IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.
REQ-015 beep  output  1  done alarm.

Function
REQ-016 Button press SHALL be detected as input low this cycle and high in the previous sampled cycle; holding a button low SHALL count as one press.
REQ-017 A press, key, tick or door event sampled at edge N SHALL be visible on registered outputs after edge N.
REQ-018 mag_on SHALL be combinational: (state==COOK) AND door_closed; opening the door SHALL drop mag_on in the same cycle.
REQ-019 Event priority within one cycle SHALL be: clear > stop > door open > countdown/expiry > start > key.
REQ-020 Key entry in IDLE or SET with key_valid=1 and key_digit<=9 SHALL shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit; the old min_tens is discarded.
REQ-021 key_digit>9 and keys in COOK, PAUSE or DONE SHALL be ignored.
REQ-022 IDLE: a key making the time nonzero -> SET; a key leaving the time 00:00 stays in IDLE; start/stop/clear are ignored.
REQ-023 SET: start with door_closed=1 -> COOK; start with door open is ignored; stop or clear -> IDLE with the time zeroed.
REQ-024 COOK: clear -> IDLE with the time zeroed; stop -> PAUSE with the time held; door open -> PAUSE with the time held.
REQ-025 COOK countdown: on tick_1hz, with no higher-priority event, the time SHALL decrement by one second in BCD. If sec_ones>0, decrement it. Otherwise sec_ones=9 and borrow from sec_tens. If sec_tens=0, sec_tens=5 and borrow from min_ones. If min_ones=0, min_ones=9 and decrement min_tens.
REQ-026 A decrement reaching 00:00 SHALL move to DONE on the same edge.
REQ-027 sec_tens values 6-9 entered by keypad SHALL be valid; e.g. 00:90 counts down in 90 ticks.
REQ-028 PAUSE: start with door_closed=1 -> COOK; stop or clear -> IDLE with the time zeroed; a door closing alone SHALL NOT resume cooking.
REQ-029 DONE: beep=1; the time stays 00:00. After BEEP_SECS ticks -> IDLE with beep=0. Any button press or the door opening -> IDLE immediately.
REQ-030 beep SHALL be 0 in all states other than DONE.

Reset
REQ-031 rst=1 SHALL force: state=IDLE, all time digits=0, beep=0, mag_on=0, internal beep counter=0, previous-button registers=1; rst takes priority over every other input, including mid-COOK.

Verification
REQ-032 Reset; keys 1,3,0 -> 01:30, state=SET; startn press with door_closed=1 -> COOK, mag_on=1 next cycle.
REQ-033 From 01:00 in COOK, one tick -> 00:59. From 00:02, two ticks -> DONE, mag_on=0, beep=1. Three further ticks -> IDLE, beep=0.
REQ-034 Door opens in COOK at 00:40 -> mag_on=0 in the same cycle, PAUSE next cycle, time frozen across ticks; closing the door alone keeps PAUSE; start -> COOK.
REQ-035 In COOK, clearn, startn and tick_1hz asserted in the same cycle -> IDLE, 00:00, mag_on=0.
REQ-036 Keys 1,2,3,4,5 -> 23:45; key_digit=12 is ignored. Entering 00:90 and starting -> DONE after exactly 90 ticks.
REQ-037 startn held low for 50 cycles in SET -> a single COOK entry. rst asserted mid-COOK -> IDLE, mag_on=0 after the edge.
